// File: rtl/sram_resp_pkg.sv
// Shared types and constants for the SRAM responder: FSM encoding,
// half-word select values and the inactive level of the SRAM strobes.
package sram_resp_pkg;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RD_LO     = 4'd1,
        RD_HI     = 4'd2,
        RD_DONE   = 4'd3,
        WR_LO     = 4'd4,
        WR_LO_REC = 4'd5,
        WR_HI     = 4'd6,
        WR_HI_REC = 4'd7,
        WR_DONE   = 4'd8
    } state_e;

    localparam logic HALF_LO     = 1'b0;
    localparam logic HALF_HI     = 1'b1;
    localparam logic STROBE_IDLE = 1'b1;
    localparam int   TIMER_W     = 3;

    function automatic logic is_access_phase(input state_e s);
        return s inside {RD_LO, RD_HI, WR_LO, WR_HI};
    endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Down-counter that times one half-word access phase; loads WAIT_STATES on
// phase entry and flags the final cycle of the phase.
module sram_phase_timer
    import sram_resp_pkg::*;
#(
    parameter int WAIT_STATES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic last
);

    logic [TIMER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = TIMER_W'(WAIT_STATES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign last = (cnt_q == '0);

endmodule

// File: rtl/sram_responder.sv
// Memory-bus responder that turns 32-bit word reads/writes into two 16-bit
// asynchronous SRAM accesses (low half first). All outputs are registered.
module sram_responder
    import sram_resp_pkg::*;
#(
    parameter int ADDR_W      = 15,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       fromCPU,
    input  logic              wRAM,
    input  logic              readstart,
    output logic [31:0]       toCPU,
    output logic              readrdy,
    output logic              saverdy,
    output logic              proto_err,
    output logic [ADDR_W:0]   sram_addr,
    input  logic [15:0]       sram_dq_i,
    output logic [15:0]       sram_dq_o,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [15:0]       rd_lo_q, rd_lo_d;
    logic [31:0]       to_cpu_q, to_cpu_d;
    logic [ADDR_W:0]   sram_addr_q, sram_addr_d;
    logic [15:0]       dq_o_q, dq_o_d;
    logic              readrdy_q, readrdy_d, saverdy_q, saverdy_d;
    logic              proto_err_q, proto_err_d, dq_oe_q, dq_oe_d;
    logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d, lb_n_q, lb_n_d;
    logic              phase_load, phase_last;

    sram_phase_timer #(.WAIT_STATES(WAIT_STATES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (phase_load),
        .last (phase_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (readstart) begin
                    state_d = RD_LO;
                end else if (wRAM) begin
                    state_d = WR_LO;
                end
            end
            RD_LO:     if (phase_last) state_d = RD_HI;
            RD_HI:     if (phase_last) state_d = RD_DONE;
            RD_DONE:   state_d = IDLE;
            WR_LO:     if (phase_last) state_d = WR_LO_REC;
            WR_LO_REC: state_d = WR_HI;
            WR_HI:     if (phase_last) state_d = WR_HI_REC;
            WR_HI_REC: state_d = WR_DONE;
            WR_DONE:   state_d = IDLE;
            default:   state_d = IDLE;
        endcase
        phase_load = (state_d != state_q) && is_access_phase(state_d);
    end

    // Request latches and read-data assembly; the low half is parked until
    // the high half arrives so toCPU only changes when a read completes.
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        rd_lo_d     = rd_lo_q;
        to_cpu_d    = to_cpu_q;
        proto_err_d = proto_err_q | ((state_q != IDLE) && readstart);
        if (state_q == IDLE && readstart) begin
            addr_d = addr;
        end else if (state_q == IDLE && wRAM) begin
            addr_d = addr;
            data_d = fromCPU;
        end
        if (state_q == RD_LO && phase_last) begin
            rd_lo_d = sram_dq_i;
        end
        if (state_q == RD_HI && phase_last) begin
            to_cpu_d = {sram_dq_i, rd_lo_q};
        end
    end

    // Outputs are decoded from the next state so the registered pins line up
    // with the state they belong to.
    always_comb begin
        sram_addr_d = sram_addr_q;
        dq_o_d      = dq_o_q;
        dq_oe_d     = 1'b0;
        ce_n_d      = STROBE_IDLE;
        oe_n_d      = STROBE_IDLE;
        we_n_d      = STROBE_IDLE;
        ub_n_d      = STROBE_IDLE;
        lb_n_d      = STROBE_IDLE;
        readrdy_d   = 1'b0;
        saverdy_d   = 1'b0;
        case (state_d)
            RD_LO, RD_HI: begin
                ce_n_d      = 1'b0;
                oe_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                lb_n_d      = 1'b0;
                sram_addr_d = {addr_d, (state_d == RD_HI) ? HALF_HI : HALF_LO};
            end
            RD_DONE: readrdy_d = 1'b1;
            WR_LO, WR_HI: begin
                ce_n_d      = 1'b0;
                we_n_d      = 1'b0;
                ub_n_d      = 1'b0;
                lb_n_d      = 1'b0;
                dq_oe_d     = 1'b1;
                sram_addr_d = {addr_d, (state_d == WR_HI) ? HALF_HI : HALF_LO};
                dq_o_d      = (state_d == WR_HI) ? data_d[31:16] : data_d[15:0];
            end
            WR_LO_REC, WR_HI_REC: begin
                ce_n_d  = 1'b0;
                ub_n_d  = 1'b0;
                lb_n_d  = 1'b0;
                dq_oe_d = 1'b1;
            end
            WR_DONE: saverdy_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cpu_q    <= '0;
            sram_addr_q <= '0;
            dq_o_q      <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= STROBE_IDLE;
            oe_n_q      <= STROBE_IDLE;
            we_n_q      <= STROBE_IDLE;
            ub_n_q      <= STROBE_IDLE;
            lb_n_q      <= STROBE_IDLE;
            readrdy_q   <= 1'b0;
            saverdy_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            to_cpu_q    <= to_cpu_d;
            sram_addr_q <= sram_addr_d;
            dq_o_q      <= dq_o_d;
            dq_oe_q     <= dq_oe_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            ub_n_q      <= ub_n_d;
            lb_n_q      <= lb_n_d;
            readrdy_q   <= readrdy_d;
            saverdy_q   <= saverdy_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        data_q  <= data_d;
        rd_lo_q <= rd_lo_d;
    end

    assign toCPU      = to_cpu_q;
    assign readrdy    = readrdy_q;
    assign saverdy    = saverdy_q;
    assign proto_err  = proto_err_q;
    assign sram_addr  = sram_addr_q;
    assign sram_dq_o  = dq_o_q;
    assign sram_dq_oe = dq_oe_q;
    assign sram_ce_n  = ce_n_q;
    assign sram_oe_n  = oe_n_q;
    assign sram_we_n  = we_n_q;
    assign sram_ub_n  = ub_n_q;
    assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: three instances (WAIT_STATES 1, 0, 3), each with
// its own behavioural asynchronous SRAM, driven from shared bus stimulus.
module tb_sram_responder;

    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0] addr = '0;
    logic [31:0]   fromCPU = '0;
    logic          wRAM = 1'b0;
    logic          readstart = 1'b0;

    logic [31:0] toCPU1, toCPU0, toCPU3;
    logic        rdy1, rdy0, rdy3, sv1, sv0, sv3, perr1, perr0, perr3;
    logic [AW:0] sa1, sa0, sa3;
    logic [15:0] dqi1, dqi0, dqi3, dqo1, dqo0, dqo3;
    logic        oe1, oe0, oe3, ce1, ce0, ce3, oen1, oen0, oen3;
    logic        wen1, wen0, wen3, ub1, ub0, ub3, lb1, lb0, lb3;

    logic [15:0] m1 [0:65535];
    logic [15:0] m0 [0:65535];
    logic [15:0] m3 [0:65535];
    logic        pre_en = 1'b0;
    logic [15:0] pre_a = '0;
    logic [15:0] pre_d = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] exp_q1[$];
    logic [31:0] exp_q0[$];
    logic [31:0] exp_q3[$];
    logic [31:0] exp_mem[$];

    sram_responder #(.ADDR_W(AW), .WAIT_STATES(1)) u_dut (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU1), .readrdy(rdy1), .saverdy(sv1),
        .proto_err(perr1), .sram_addr(sa1), .sram_dq_i(dqi1), .sram_dq_o(dqo1),
        .sram_dq_oe(oe1), .sram_ce_n(ce1), .sram_oe_n(oen1), .sram_we_n(wen1),
        .sram_ub_n(ub1), .sram_lb_n(lb1)
    );

    sram_responder #(.ADDR_W(AW), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU0), .readrdy(rdy0), .saverdy(sv0),
        .proto_err(perr0), .sram_addr(sa0), .sram_dq_i(dqi0), .sram_dq_o(dqo0),
        .sram_dq_oe(oe0), .sram_ce_n(ce0), .sram_oe_n(oen0), .sram_we_n(wen0),
        .sram_ub_n(ub0), .sram_lb_n(lb0)
    );

    sram_responder #(.ADDR_W(AW), .WAIT_STATES(3)) u_dut_w3 (
        .clk(clk), .rst(rst), .addr(addr), .fromCPU(fromCPU), .wRAM(wRAM),
        .readstart(readstart), .toCPU(toCPU3), .readrdy(rdy3), .saverdy(sv3),
        .proto_err(perr3), .sram_addr(sa3), .sram_dq_i(dqi3), .sram_dq_o(dqo3),
        .sram_dq_oe(oe3), .sram_ce_n(ce3), .sram_oe_n(oen3), .sram_we_n(wen3),
        .sram_ub_n(ub3), .sram_lb_n(lb3)
    );

    // Asynchronous SRAM models: combinational read, write while we_n is low
    assign dqi1 = (!ce1 && !oen1) ? m1[sa1] : 16'hDEAD;
    assign dqi0 = (!ce0 && !oen0) ? m0[sa0] : 16'hDEAD;
    assign dqi3 = (!ce3 && !oen3) ? m3[sa3] : 16'hDEAD;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pre_en) begin
            m1[pre_a] <= pre_d;
            m0[pre_a] <= pre_d;
            m3[pre_a] <= pre_d;
        end
        if (!ce1 && !wen1 && oe1 && !ub1 && !lb1) m1[sa1] <= dqo1;
        if (!ce0 && !wen0 && oe0 && !ub0 && !lb0) m0[sa0] <= dqo0;
        if (!ce3 && !wen3 && oe3 && !ub3 && !lb3) m3[sa3] <= dqo3;
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_en = 1'b1;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic pulse_read(input logic [AW-1:0] a, output int t0);
        addr      = a;
        readstart = 1'b1;
        t0        = cyc;
        @(negedge clk);
        readstart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({ce1, oen1, wen1, ub1, lb1} !== 5'b11111) begin
            errors++;
            $display("FAIL reset_strobes: got %b expected 11111", {ce1, oen1, wen1, ub1, lb1});
        end
        checks++;
        if ({oe1, rdy1, sv1, perr1} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 0000", {oe1, rdy1, sv1, perr1});
        end
        checks++;
        if ({toCPU1, sa1, dqo1} !== '0) begin
            errors++;
            $display("FAIL reset_data: toCPU %h addr %h dq_o %h expected all zero", toCPU1, sa1, dqo1);
        end
        checks++;
        if ({ce0, oen0, wen0, ub0, lb0, oe0, rdy0, sv0, perr0, ce3, oen3, wen3, ub3, lb3, oe3, rdy3, sv3, perr3}
            !== 18'b11111_0000_11111_0000) begin
            errors++;
            $display("FAIL reset_other_instances: got %b expected 111110000111110000",
                     {ce0, oen0, wen0, ub0, lb0, oe0, rdy0, sv0, perr0, ce3, oen3, wen3, ub3, lb3, oe3, rdy3, sv3, perr3});
        end
        checks++;
        if ({toCPU0, sa0, dqo0, toCPU3, sa3, dqo3} !== '0) begin
            errors++;
            $display("FAIL reset_other_data: toCPU0 %h toCPU3 %h expected 0", toCPU0, toCPU3);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_read();
        int t0, lat, nrdy, rd_cyc;
        preload(16'h0024, 16'hBEEF);
        preload(16'h0025, 16'hCAFE);
        exp_q1.push_back(32'hCAFEBEEF);
        pulse_read(15'h0012, t0);
        nrdy = 0;
        rd_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) @(negedge clk);
            lat = cyc - t0;
            checks++;
            if (oen1 !== ((lat >= 1 && lat <= 4) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL read_oe_n cycle %0d: got %b", lat, oen1);
            end
            if (rdy1 === 1'b1) begin
                nrdy++;
                rd_cyc = lat;
                checks++;
                if (exp_q1.size() == 0) begin
                    errors++;
                    $display("FAIL read_data: unexpected readrdy with toCPU %h", toCPU1);
                end else if (toCPU1 !== exp_q1.pop_front()) begin
                    errors++;
                    $display("FAIL read_data: got %h expected cafebeef", toCPU1);
                end
            end
        end
        checks++;
        if (rd_cyc != 5 || nrdy != 1) begin
            errors++;
            $display("FAIL read_latency: readrdy cycle %0d count %0d expected cycle 5 count 1", rd_cyc, nrdy);
        end
        exp_q1.delete();
        repeat (8) @(negedge clk);
    endtask

    task automatic test_write();
        int t0, lat, nsv, sv_cyc;
        logic [31:0] e;
        exp_mem.push_back({16'hFFFE, 16'h5678});
        exp_mem.push_back({16'hFFFF, 16'h1234});
        addr    = 15'h7FFF;
        fromCPU = 32'h12345678;
        wRAM    = 1'b1;
        t0      = cyc;
        nsv     = 0;
        sv_cyc  = -1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat = cyc - t0;
            checks++;
            if (wen1 !== ((lat == 1 || lat == 2 || lat == 4 || lat == 5) ? 1'b0 : 1'b1)) begin
                errors++;
                $display("FAIL write_we_n cycle %0d: got %b", lat, wen1);
            end
            if (lat == 8) begin
                checks++;
                if (oe1 !== 1'b0) begin
                    errors++;
                    $display("FAIL write_dq_oe_after: got %b expected 0", oe1);
                end
            end
            if (sv1 === 1'b1) begin
                nsv++;
                sv_cyc = lat;
                wRAM = 1'b0;
            end
        end
        wRAM = 1'b0;
        checks++;
        if (sv_cyc != 7 || nsv != 1) begin
            errors++;
            $display("FAIL write_latency: saverdy cycle %0d count %0d expected cycle 7 count 1", sv_cyc, nsv);
        end
        while (exp_mem.size() != 0) begin
            e = exp_mem.pop_front();
            checks++;
            if (m1[e[31:16]] !== e[15:0]) begin
                errors++;
                $display("FAIL write_mem[%h]: got %h expected %h", e[31:16], m1[e[31:16]], e[15:0]);
            end
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic test_simultaneous();
        int t0, lat, rd_cyc, sv_cyc;
        logic [31:0] e;
        preload(16'h0060, 16'h1111);
        preload(16'h0061, 16'h2222);
        exp_q1.push_back(32'h22221111);
        exp_mem.push_back({16'h0060, 16'h5A5A});
        exp_mem.push_back({16'h0061, 16'hA5A5});
        addr      = 15'h0030;
        fromCPU   = 32'hA5A55A5A;
        wRAM      = 1'b1;
        readstart = 1'b1;
        t0        = cyc;
        rd_cyc    = -1;
        sv_cyc    = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            readstart = 1'b0;
            lat = cyc - t0;
            if (rdy1 === 1'b1) begin
                rd_cyc = lat;
                checks++;
                if (exp_q1.size() == 0 || toCPU1 !== exp_q1.pop_front()) begin
                    errors++;
                    $display("FAIL both_read_data: got %h expected 22221111", toCPU1);
                end
            end
            if (sv1 === 1'b1) begin
                sv_cyc = lat;
                wRAM = 1'b0;
            end
        end
        wRAM = 1'b0;
        checks++;
        if (rd_cyc != 5 || sv_cyc != 13) begin
            errors++;
            $display("FAIL both_order: readrdy cycle %0d saverdy cycle %0d expected 5 and 13", rd_cyc, sv_cyc);
        end
        checks++;
        if (perr1 !== 1'b0) begin
            errors++;
            $display("FAIL both_proto_err: got %b expected 0", perr1);
        end
        while (exp_mem.size() != 0) begin
            e = exp_mem.pop_front();
            checks++;
            if (m1[e[31:16]] !== e[15:0]) begin
                errors++;
                $display("FAIL both_mem[%h]: got %h expected %h", e[31:16], m1[e[31:16]], e[15:0]);
            end
        end
        exp_q1.delete();
        repeat (6) @(negedge clk);
    endtask

    task automatic test_busy_read();
        int t0, lat, nrdy, rd_cyc;
        exp_q1.push_back(32'hCAFEBEEF);
        pulse_read(15'h0012, t0);
        nrdy = 0;
        rd_cyc = -1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            lat = cyc - t0;
            readstart = (lat == 3);
            if (lat == 3) addr = 15'h0025;
            if (lat == 3) begin
                checks++;
                if (perr1 !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_err_before: got %b expected 0", perr1);
                end
            end
            if (rdy1 === 1'b1) begin
                nrdy++;
                rd_cyc = lat;
                checks++;
                if (exp_q1.size() == 0 || toCPU1 !== exp_q1.pop_front()) begin
                    errors++;
                    $display("FAIL busy_read_data: got %h expected cafebeef", toCPU1);
                end
            end
        end
        readstart = 1'b0;
        checks++;
        if (rd_cyc != 5 || nrdy != 1) begin
            errors++;
            $display("FAIL busy_ignored: readrdy cycle %0d count %0d expected cycle 5 count 1", rd_cyc, nrdy);
        end
        checks++;
        if (perr1 !== 1'b1) begin
            errors++;
            $display("FAIL busy_err_sticky: got %b expected 1", perr1);
        end
        exp_q1.delete();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        int nsv;
        preload(16'h0080, 16'h1111);
        preload(16'h0081, 16'h7777);
        addr    = 15'h0040;
        fromCPU = 32'hDEADBEEF;
        wRAM    = 1'b1;
        @(negedge clk);
        checks++;
        if (wen1 !== 1'b0) begin
            errors++;
            $display("FAIL rstwr_in_wr_lo: we_n got %b expected 0", wen1);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({ce1, oen1, wen1, ub1, lb1, oe1, rdy1, sv1, perr1} !== 9'b11111_0000) begin
            errors++;
            $display("FAIL rstwr_async: got %b expected 111110000", {ce1, oen1, wen1, ub1, lb1, oe1, rdy1, sv1, perr1});
        end
        checks++;
        if ({toCPU1, sa1, dqo1} !== '0) begin
            errors++;
            $display("FAIL rstwr_data: toCPU %h addr %h dq_o %h expected 0", toCPU1, sa1, dqo1);
        end
        wRAM = 1'b0;
        nsv  = 0;
        repeat (3) begin
            @(negedge clk);
            if (sv1 === 1'b1) nsv++;
        end
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (sv1 === 1'b1) nsv++;
        end
        checks++;
        if (nsv != 0) begin
            errors++;
            $display("FAIL rstwr_no_saverdy: got %0d pulses expected 0", nsv);
        end
        checks++;
        if (m1[16'h0081] !== 16'h7777) begin
            errors++;
            $display("FAIL rstwr_high_half: got %h expected 7777", m1[16'h0081]);
        end
    endtask

    task automatic test_wait_states();
        int t0, lat, r0, r3;
        exp_q0.push_back(32'hCAFEBEEF);
        exp_q3.push_back(32'hCAFEBEEF);
        pulse_read(15'h0012, t0);
        r0 = -1;
        r3 = -1;
        for (int k = 0; k < 14; k++) begin
            if (k > 0) @(negedge clk);
            lat = cyc - t0;
            if (rdy0 === 1'b1) begin
                r0 = lat;
                checks++;
                if (exp_q0.size() == 0 || toCPU0 !== exp_q0.pop_front()) begin
                    errors++;
                    $display("FAIL w0_data: got %h expected cafebeef", toCPU0);
                end
            end
            if (rdy3 === 1'b1) begin
                r3 = lat;
                checks++;
                if (exp_q3.size() == 0 || toCPU3 !== exp_q3.pop_front()) begin
                    errors++;
                    $display("FAIL w3_data: got %h expected cafebeef", toCPU3);
                end
            end
        end
        checks++;
        if (r0 != 3) begin
            errors++;
            $display("FAIL w0_latency: readrdy cycle %0d expected 3", r0);
        end
        checks++;
        if (r3 != 9) begin
            errors++;
            $display("FAIL w3_latency: readrdy cycle %0d expected 9", r3);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_simultaneous();
        test_busy_read();
        test_reset_mid_write();
        test_wait_states();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
